// File: rtl/seq_add64_iter_pkg.sv
// Shared definitions for the iterative 64-bit add/sub unit.
package seq_add64_iter_pkg;

  localparam int unsigned XLEN    = 64;
  localparam int unsigned SLICE_W = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam logic [1:0] LAST_IDX_D = 2'd3;
  localparam logic [1:0] LAST_IDX_W = 2'd1;

  // Index of the final slice for the requested operand width.
  function automatic logic [1:0] last_idx(input logic word);
    return word ? LAST_IDX_W : LAST_IDX_D;
  endfunction

endpackage

// File: rtl/sixteenbit_lca.sv
// Combinational 16-bit lookahead slice adder with group generate/propagate.
module sixteenbit_lca
  import seq_add64_iter_pkg::*;
(
  input  logic [SLICE_W-1:0] a_i,
  input  logic [SLICE_W-1:0] b_i,
  input  logic               c_i,
  output logic [SLICE_W-1:0] s_o,
  output logic               g_o,
  output logic               p_o
);

  logic [SLICE_W-1:0] gen;
  logic [SLICE_W-1:0] prop;
  logic [SLICE_W:0]   carry;
  logic               grp_g;

  // Bit carries, sum, and slice-level generate/propagate (independent of c_i).
  always_comb begin
    gen      = a_i & b_i;
    prop     = a_i ^ b_i;
    carry    = '0;
    carry[0] = c_i;
    grp_g    = 1'b0;
    for (int i = 0; i < int'(SLICE_W); i++) begin
      carry[i+1] = gen[i] | (prop[i] & carry[i]);
      grp_g      = gen[i] | (prop[i] & grp_g);
    end
    s_o = prop ^ carry[SLICE_W-1:0];
    g_o = grp_g;
    p_o = &prop;
  end

endmodule

// File: rtl/seq_add64_iter.sv
// Multi-cycle 64-bit add/sub: one 16-bit slice per cycle through a shared slice adder.
module seq_add64_iter
  import seq_add64_iter_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            op_sub,
  input  logic            op_word,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            carry_out,
  output logic            overflow
);

  state_e            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic              carry_q, carry_d;
  logic              word_q, word_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;  // already inverted for subtraction
  logic [XLEN-1:0]   res_q, res_d;

  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic [SLICE_W-1:0] slice_s;
  logic               slice_g;
  logic               slice_p;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StRun;
      StRun:   if (idx_q == last_idx(word_q)) state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs.
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
  end

  // Select the active slice of the latched operands.
  always_comb begin
    unique case (idx_q)
      2'd0:    begin slice_a = a_q[15:0];  slice_b = b_q[15:0];  end
      2'd1:    begin slice_a = a_q[31:16]; slice_b = b_q[31:16]; end
      2'd2:    begin slice_a = a_q[47:32]; slice_b = b_q[47:32]; end
      default: begin slice_a = a_q[63:48]; slice_b = b_q[63:48]; end
    endcase
  end

  sixteenbit_lca u_slice (
    .a_i (slice_a),
    .b_i (slice_b),
    .c_i (carry_q),
    .s_o (slice_s),
    .g_o (slice_g),
    .p_o (slice_p)
  );

  // Datapath next state: latch on accept, accumulate one slice per RUN cycle.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    word_d  = word_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    res_d   = res_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b ^ {XLEN{op_sub}};
          word_d  = op_word;
          carry_d = op_sub;
          idx_d   = 2'd0;
          res_d   = '0;
        end
      end
      StRun: begin
        unique case (idx_q)
          2'd0:    res_d[15:0]  = slice_s;
          2'd1:    res_d[31:16] = slice_s;
          2'd2:    res_d[47:32] = slice_s;
          default: res_d[63:48] = slice_s;
        endcase
        carry_d = slice_g | (slice_p & carry_q);
        idx_d   = idx_q + 2'd1;
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      word_q  <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= 2'd0;
      res_q   <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      word_q  <= word_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
    end
  end

  // Result and flags; W-form sign-extends and checks bit 31.
  always_comb begin
    if (word_q) begin
      result   = {{32{res_q[31]}}, res_q[31:0]};
      overflow = (a_q[31] == b_q[31]) & (res_q[31] != a_q[31]);
    end else begin
      result   = res_q;
      overflow = (a_q[63] == b_q[63]) & (res_q[63] != a_q[63]);
    end
    carry_out = carry_q;
  end

endmodule

// File: tb/tb_seq_add64_iter.sv
// Self-checking bench for seq_add64_iter: directed vector table, reset abort, random stream.
module tb_seq_add64_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        op_sub;
  logic        op_word;
  logic [63:0] a;
  logic [63:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        carry_out;
  logic        overflow;

  seq_add64_iter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_sub    (op_sub),
    .op_word   (op_word),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        sub;
    logic        word;
    logic [63:0] res;
    logic        c;
    logic        ov;
    int          hold;
  } vec_t;

  typedef struct {
    logic [63:0] res;
    logic        c;
    logic        ov;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, got, exp);
    end
  endtask

  // Reference: plain wide addition with inverted B and carry-in for subtract.
  function automatic exp_t model(input logic [63:0] ma, input logic [63:0] mb,
                                 input logic sub, input logic word);
    exp_t        e;
    logic [63:0] bb;
    logic [64:0] t64;
    logic [32:0] t32;
    bb = sub ? ~mb : mb;
    if (!word) begin
      t64   = {1'b0, ma} + {1'b0, bb} + {64'd0, sub};
      e.res = t64[63:0];
      e.c   = t64[64];
      e.ov  = (ma[63] == bb[63]) && (t64[63] != ma[63]);
      e.lat = 4;
    end else begin
      t32   = {1'b0, ma[31:0]} + {1'b0, bb[31:0]} + {32'd0, sub};
      e.res = {{32{t32[31]}}, t32[31:0]};
      e.c   = t32[32];
      e.ov  = (ma[31] == bb[31]) && (t32[31] != ma[31]);
      e.lat = 2;
    end
    e.acc_cyc = 0;
    return e;
  endfunction

  // One request with out_ready low until the result appears, then held for v.hold cycles.
  task automatic run_vec(input vec_t v);
    exp_t e;
    int   n;
    int   lat;
    logic frozen;
    @(negedge clk);
    a = v.a; b = v.b; op_sub = v.sub; op_word = v.word;
    in_valid = 1'b1; out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    e.res = v.res; e.c = v.c; e.ov = v.ov; e.lat = v.word ? 2 : 4; e.acc_cyc = 0;
    sb_q.push_back(e);
    #1;
    in_valid = 1'b0;
    // Operand changes while running must not matter.
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    op_sub = ~op_sub; op_word = ~op_word;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 20);
    check("latency", 64'(lat), 64'(e.lat));
    if (sb_q.size() == 0) begin
      check("scoreboard_nonempty", 64'd0, 64'd1);
    end else begin
      e = sb_q.pop_front();
      check("result", result, e.res);
      check("carry_out", {63'd0, carry_out}, {63'd0, e.c});
      check("overflow", {63'd0, overflow}, {63'd0, e.ov});
    end
    for (int i = 0; i < v.hold; i++) begin
      @(posedge clk);
      #1;
      frozen = out_valid && !in_ready && (result == e.res) && (carry_out == e.c) &&
               (overflow == e.ov);
      check("hold_frozen", {63'd0, frozen}, 64'd1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("handshake_to_idle", {62'd0, out_valid, in_ready}, 64'd1);
  endtask

  vec_t vecs[7];

  initial begin
    exp_t e;
    int   drained;
    int   completed;
    logic saw_valid;

    vecs[0] = '{64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h0000_0001_0000_0000,
                1'b0, 1'b0, 0};
    vecs[1] = '{64'd5, 64'd7, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 0};
    vecs[2] = '{64'h0000_0000_7FFF_FFFF, 64'd1, 1'b0, 1'b1, 64'hFFFF_FFFF_8000_0000,
                1'b0, 1'b1, 0};
    vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 10};
    vecs[4] = '{64'h0000_0000_8000_0000, 64'd1, 1'b1, 1'b1, 64'h0000_0000_7FFF_FFFF,
                1'b1, 1'b1, 0};
    vecs[5] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000,
                1'b0, 1'b1, 2};
    vecs[6] = '{64'hDEAD_BEEF_0000_0001, 64'h1234_5678_0000_0002, 1'b0, 1'b1, 64'd3,
                1'b0, 1'b0, 0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op_sub = 1'b0; op_word = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_in_ready", {63'd0, in_ready}, 64'd1);
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_result", result, 64'd0);
    check("reset_flags", {62'd0, carry_out, overflow}, 64'd0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset while slice 2 is pending aborts the operation.
    @(negedge clk);
    a = 64'h1111_2222_3333_4444; b = 64'h5555_6666_7777_8888;
    op_sub = 1'b0; op_word = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_out_valid", {63'd0, out_valid}, 64'd0);
    check("abort_result", result, 64'd0);
    check("abort_carry", {63'd0, carry_out}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_valid = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (out_valid) saw_valid = 1'b1;
    end
    check("abort_no_output", {63'd0, saw_valid}, 64'd0);
    check("abort_in_ready", {63'd0, in_ready}, 64'd1);
    out_ready = 1'b0;
    run_vec('{64'd3, 64'd4, 1'b0, 1'b0, 64'd7, 1'b0, 1'b0, 0});

    // Back-to-back random stream with in_valid and out_ready held high.
    completed = 0;
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 600; k++) begin
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          check("stream_unexpected_output", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          check("stream_result", result, e.res);
          check("stream_flags", {62'd0, carry_out, overflow}, {62'd0, e.c, e.ov});
          check("stream_latency", 64'(cyc - e.acc_cyc), 64'(e.lat));
          completed++;
        end
      end
      a = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
      b = ($urandom_range(0, 7) == 0) ? 64'h8000_0000_8000_0000 : {$urandom, $urandom};
      op_sub  = 1'($urandom_range(0, 1));
      op_word = 1'($urandom_range(0, 1));
      if (in_ready) begin
        e = model(a, b, op_sub, op_word);
        e.acc_cyc = cyc + 1;
        sb_q.push_back(e);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    drained = 0;
    while (sb_q.size() != 0 && drained < 20) begin
      if (out_valid) begin
        e = sb_q.pop_front();
        check("drain_result", result, e.res);
        completed++;
      end
      @(negedge clk);
      drained++;
    end
    check("stream_drained", 64'(sb_q.size()), 64'd0);
    check("stream_progress", {63'd0, (completed > 100)}, 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
